// File: rtl/nibble_serial_adder_if.sv
// Operand and result handshake bundle for nibble_serial_adder.
// The master drives operands and result acceptance; the slave is the adder.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit slice, LS nibble first.
// Result (sum, carry-out, signed overflow) is held until the consumer accepts it.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_serial_adder_if.slave bus
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] a_sh_q,      a_sh_d;
  logic [WIDTH-1:0] b_sh_q,      b_sh_d;
  logic [WIDTH-1:0] sum_sh_q,    sum_sh_d;
  logic             carry_q,     carry_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic             a_msb_q,     a_msb_d;
  logic             b_msb_q,     b_msb_d;
  logic [WIDTH-1:0] sum_q,       sum_d;
  logic             cout_q,      cout_d;
  logic             ovf_q,       ovf_d;
  logic             out_valid_q, out_valid_d;

  logic [4:0]       nib_sum;
  logic [WIDTH-1:0] sum_shift_next;
  logic             last_nibble;

  // The single shared 4-bit slice; each new nibble enters the sum register from the top
  // so after N shifts the least-significant nibble has reached bit 0.
  always_comb begin
    nib_sum        = {1'b0, a_sh_q[3:0]} + {1'b0, b_sh_q[3:0]} + {4'b0000, carry_q};
    sum_shift_next = (sum_sh_q >> 4) | (WIDTH'(nib_sum[3:0]) << (WIDTH - 4));
    last_nibble    = (cnt_q == CW'(N - 1));
  end

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_sh_d    = sum_sh_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          sum_sh_d = '0;
          carry_d  = bus.cin;
          cnt_d    = '0;
          a_msb_d  = bus.a[WIDTH-1];
          b_msb_d  = bus.b[WIDTH-1];
          state_d  = RUN;
        end
      end

      RUN: begin
        a_sh_d   = a_sh_q >> 4;
        b_sh_d   = b_sh_q >> 4;
        sum_sh_d = sum_shift_next;
        carry_d  = nib_sum[4];
        cnt_d    = cnt_q + CW'(1);
        if (last_nibble) begin
          // Overflow uses the sign bits captured at acceptance, not the shifted operands.
          sum_d       = sum_shift_next;
          cout_d      = nib_sum[4];
          ovf_d       = (a_msb_q == b_msb_q) && (sum_shift_next[WIDTH-1] != a_msb_q);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_sh_q    <= sum_sh_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  // Accepting and presenting are mutually exclusive phases of one operation.
  a_no_overlap: assert property (@(posedge clk) disable iff (rst)
    !(bus.in_ready && bus.out_valid));

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: expected results are queued at operand
// acceptance and compared when the result handshake completes.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  exp_t sb[$];
  logic prev_valid  = 1'b0;
  logic expect_low  = 1'b0;

  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: push model results on accept, pop and compare on result handshake.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      sb.delete();
      prev_valid = 1'b0;
      expect_low = 1'b0;
    end else begin
      if (expect_low) begin
        checkOutput("valid_drop", 32'(bus.out_valid), 32'd0);
        checkOutput("in_ready_rise", 32'(bus.in_ready), 32'd1);
        expect_low = 1'b0;
      end
      if (bus.out_valid === 1'b1 && prev_valid !== 1'b1) begin
        checkOutput("pending_at_valid", 32'(sb.size()), 32'd1);
        if (sb.size() > 0)
          checkOutput("latency", 32'(cyc - sb[0].acc_cyc), 32'(N));
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && sb.size() > 0) begin : pop_blk
        exp_t e;
        e = sb.pop_front();
        checkOutput("sum", 32'(bus.sum), 32'(e.sum));
        checkOutput("cout", 32'(bus.cout), 32'(e.cout));
        checkOutput("ovf", 32'(bus.ovf), 32'(e.ovf));
        expect_low = 1'b1;
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin : push_blk
        exp_t e;
        logic [WIDTH:0] full;
        full      = {1'b0, bus.a} + {1'b0, bus.b} + (WIDTH+1)'(bus.cin);
        e.sum     = full[WIDTH-1:0];
        e.cout    = full[WIDTH];
        e.ovf     = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (full[WIDTH-1] != bus.a[WIDTH-1]);
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
      end
      prev_valid = bus.out_valid;
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
    int   n;
    logic acc;
    n            = 0;
    acc          = 1'b0;
    bus.a        = av;
    bus.b        = bv;
    bus.cin      = cv;
    bus.in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = (bus.in_ready === 1'b1) && (rst === 1'b0);
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) checkOutput("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    @(negedge clk);
    checkOutput({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, "_sum"}, 32'(bus.sum), 32'd0);
    checkOutput({tag, "_cout"}, 32'(bus.cout), 32'd0);
    checkOutput({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
    checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] tab_a   [5] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000};
  logic [WIDTH-1:0] tab_b   [5] = '{16'h4321, 16'h0001, 16'hFFFF, 16'h0000, 16'h8000};
  logic             tab_cin [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkReset("init");

    // Directed corner vectors: nibble-to-nibble carry ripple and signed overflow.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(tab_a[i], tab_b[i], tab_cin[i]);
      waitDrain();
    end

    // Backpressure: result must hold and no new operand may be taken.
    bus.out_ready = 1'b0;
    applyStimulus(16'h00F0, 16'h0F10, 1'b0);
    begin
      int n;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
      bus.cin      = 1'($urandom);
      @(negedge clk);
      checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("bp_sum", 32'(bus.sum), 32'h1000);
      checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    waitDrain();
    applyStimulus(16'hABCD, 16'h1111, 1'b1);
    waitDrain();

    // Back-to-back random operations.
    for (int i = 0; i < 8; i++)
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom));
    waitDrain();

    // Reset while an operation is in RUN: it must vanish without a result.
    applyStimulus(16'h5A5A, 16'h0F0F, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkReset("run_reset");
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      checkOutput("abort_valid", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(16'h0001, 16'h0002, 1'b0);
    waitDrain();

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, %0d vectors applied", vectors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder built around a single 4-bit add slice.
- Accepts two WIDTH-bit operands plus carry-in through a valid/ready handshake.
- Adds one nibble per clock, least-significant first, carrying between cycles.
- Presents the registered sum, carry-out and signed-overflow flag to a downstream consumer through a valid/ready handshake.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4, otherwise elaboration fails.
- N (derived, WIDTH/4), number of nibble cycles per operation; not user-settable.

Ports:
- clk  input  1  single clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a, b, cin are valid
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry into bit 0
- out_valid  output  1  sum, cout and ovf hold a completed result
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  two's-complement overflow

Behaviour:
- Reset (rst high at a clock edge, in any state):
  - state goes to IDLE; out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - An operation in progress is discarded; no partial result ever appears.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE), combinational from state only. out_valid = (state==DONE), registered.
- IDLE:
  - On in_valid & in_ready at an edge, capture a, b and cin into shift registers, carry register <= cin, nibble counter <= 0.
  - Capture a[WIDTH-1] and b[WIDTH-1] for the overflow calculation, then go to RUN.
- RUN (exactly N cycles):
  - Each edge computes {c, s4} = a_sh[3:0] + b_sh[3:0] + carry.
  - s4 shifts into the top of the internal sum shift register; a_sh and b_sh shift right 4; carry <= c; counter increments.
  - On the N-th RUN edge the counter is N-1: load the sum output from the completed shift value, cout <= c, ovf <= (a_msb == b_msb) & (sum[WIDTH-1] != a_msb). Go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf are stable.
  - On out_ready at an edge, go to IDLE; in_ready rises in the next cycle.
  - Held indefinitely while out_ready=0.
- Latency: if the input handshake occurs at edge k, out_valid is high after edge k+N.
  - Minimum period is N+2 cycles (IDLE, N x RUN, DONE).
  - No overlap: a new operand is never accepted in the same cycle the result handshake completes.
- in_valid in RUN or DONE is ignored; no operand is captured or queued.
- After a result handshake, sum/cout/ovf keep their last value (out_valid=0) until the next result loads.
- The sum output register changes only on entry to DONE or on reset; the internal shift register is never driven to the port.
- Arithmetic:
  - Unsigned sum modulo 2^WIDTH.
  - cout is the true carry out of the MSB.
  - ovf uses operand sign bits captured at acceptance and is independent of cin except through sum.

Test Plan:
1. Assert rst for 2 cycles mid-stream -> after reset out_valid=0, sum=0x0000, cout=0, ovf=0, in_ready=1.
2. WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1 -> sum=0x5555, cout=0, ovf=0; out_valid rises exactly 4 cycles after the accept edge and lasts 1 cycle.
3. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry crosses all nibble boundaries). Also a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0.
4. a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1, ovf=1.
5. Backpressure, a=0x00F0, b=0x0F10:
   - Hold out_ready=0 for 6 cycles while pulsing in_valid with other operands.
   - Required: out_valid stays 1; sum stays 0x1000; in_ready=0; no extra capture.
   - Release out_ready -> in_ready=1 next cycle; the next operation computes correctly.
6. Reset during RUN: assert rst 2 cycles after acceptance -> no out_valid for the aborted operation. Then a=0x0001, b=0x0002 -> sum=0x0003.
